// File: rtl/sparse_triple_encoder.sv
// sparse_triple_encoder
// Takes a dense matrix, one element per cycle in raster order, and drops the
// zero elements. Each nonzero element leaves as a (row, col, val) triple,
// after a size header. A small FIFO decouples the input side from the output
// side, and both sides use ready/valid handshakes.
//
// Ports
//   clk, rst_n          clock; rst_n is a synchronous reset, active HIGH
//   in_valid_size/in_size  frame start strobe and size (0=16x16, 1=32x32)
//   in_valid/in_ready/in_val  dense element stream
//   out_valid_size/out_size   size header towards the multiplier
//   out_valid/out_ready/out_row/out_col/out_val  triple stream
//   done/nnz            one-cycle frame-complete pulse with the nonzero count
module sparse_triple_encoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int IDX_W      = 5,
  parameter int VAL_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_size,
  input  logic             in_size,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VAL_W-1:0] in_val,
  output logic             out_valid_size,
  output logic             out_size,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_row,
  output logic [IDX_W-1:0] out_col,
  output logic [VAL_W-1:0] out_val,
  output logic             done,
  output logic [10:0]      nnz
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 2 * IDX_W + VAL_W;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t                           state_q, state_d;
  logic                             size_q, size_d;
  logic [IDX_W-1:0]                 row_q, row_d, col_q, col_d;
  logic [10:0]                      nnz_q, nnz_d;
  logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                 count_q, count_d;
  logic [FIFO_DEPTH-1:0][ENT_W-1:0] fifo_mem_q;

  logic             full, empty, accept, push, pop, last_elem;
  logic [IDX_W-1:0] last_idx;
  logic [ENT_W-1:0] head;

  // in_ready looks only at the registered count. A pop in the same cycle does
  // not open a slot, so out_ready never sits on a combinational path to in_ready.
  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign last_idx  = size_q ? IDX_W'(31) : IDX_W'(15);
  assign accept    = in_valid & in_ready;
  assign push      = accept & (in_val != '0);
  assign pop       = out_valid & out_ready;
  assign last_elem = accept & (row_q == last_idx) & (col_q == last_idx);
  assign head      = fifo_mem_q[rd_ptr_q];

  // State register. rst_n is active high despite its name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= S_IDLE;
      size_q   <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      nnz_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      row_q    <= row_d;
      col_q    <= col_d;
      nnz_q    <= nnz_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The storage needs no reset: its contents are never visible while empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {row_q, col_q, in_val};
  end

  // Counters and FIFO pointers.
  always_comb begin
    size_d   = size_q;
    row_d    = row_q;
    col_d    = col_q;
    nnz_d    = nnz_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    if (state_q == S_IDLE && in_valid_size) size_d = in_size;
    if (accept) begin
      if (col_q == last_idx) begin
        col_d = '0;
        row_d = row_q + IDX_W'(1);
      end else begin
        col_d = col_q + IDX_W'(1);
      end
    end
    if (push) begin
      nnz_d    = nnz_q + 11'd1;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    // nnz_q is still shown during DONE, so clearing here takes effect in IDLE.
    if (state_q == S_DONE) begin
      size_d = 1'b0;
      row_d  = '0;
      col_d  = '0;
      nnz_d  = '0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (in_valid_size) state_d = S_HDR;
      S_HDR:    if (out_ready) state_d = S_STREAM;
      S_STREAM: if (last_elem) state_d = S_DRAIN;
      // DRAIN never pushes. count_d == 0 therefore means the last triple
      // leaves this cycle, and done follows directly after that pop.
      S_DRAIN:  if (count_d == '0) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    in_ready       = (state_q == S_STREAM) & ~full;
    out_valid_size = (state_q == S_HDR);
    out_size       = size_q;
    out_valid      = ((state_q == S_STREAM) | (state_q == S_DRAIN)) & ~empty;
    out_row        = '0;
    out_col        = '0;
    out_val        = '0;
    if (out_valid) begin
      out_row = head[ENT_W-1 -: IDX_W];
      out_col = head[VAL_W +: IDX_W];
      out_val = head[VAL_W-1:0];
    end
    done = (state_q == S_DONE);
    nnz  = done ? nnz_q : 11'd0;
  end

endmodule

// File: tb/tb_sparse_triple_encoder.sv
module tb_sparse_triple_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid_size = 1'b0, in_size = 1'b0, in_valid = 1'b0;
  logic [3:0] in_val = '0;
  logic       out_ready = 1'b1;
  logic       in_ready, out_valid_size, out_size, out_valid, done;
  logic [4:0] out_row, out_col;
  logic [3:0] out_val;
  logic [10:0] nnz;

  sparse_triple_encoder #(.FIFO_DEPTH(8), .IDX_W(5), .VAL_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_size(in_valid_size), .in_size(in_size),
    .in_valid(in_valid), .in_ready(in_ready), .in_val(in_val),
    .out_valid_size(out_valid_size), .out_size(out_size),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col), .out_val(out_val),
    .done(done), .nnz(nnz)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int r; int c; int v;} trip_t;

  logic [3:0] mat [32][32];
  trip_t expq [$];
  int checks = 0, errors = 0;
  bit chk_en = 1'b0;
  int exp_size, exp_total, exp_nnz;
  int acc_cnt, hdr_cnt, done_cnt, last_nnz;
  int first_ov_cyc, last_acc_cyc, last_pop_cyc, done_cyc;
  trip_t first_trip, last_trip;
  bit got_first;
  bit prev_done = 1'b0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the triple list is the raster scan of the nonzero cells.
  task automatic start_frame(bit sz);
    int n;
    n = sz ? 32 : 16;
    exp_size = int'(sz);
    exp_total = n * n;
    exp_nnz = 0;
    expq.delete();
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        if (mat[r][c] != 0) begin
          expq.push_back('{r, c, int'(mat[r][c])});
          exp_nnz++;
        end
    acc_cnt = 0; hdr_cnt = 0; done_cnt = 0; got_first = 1'b0;
    first_ov_cyc = -1; last_acc_cyc = -1; last_pop_cyc = -1; done_cyc = -1;
    in_valid_size = 1'b1;
    in_size = sz;
    @(posedge clk); #1;
    in_valid_size = 1'b0;
  endtask

  task automatic feed(int count);
    int n, idx, guard;
    bit a;
    n = exp_size ? 32 : 16;
    idx = 0; guard = 0;
    in_valid = 1'b1;
    in_val = mat[0][0];
    while (idx < count && guard < 20000) begin
      @(negedge clk);
      a = in_ready;
      @(posedge clk); #1;
      guard++;
      if (a) begin
        idx++;
        if (idx < count) in_val = mat[idx / n][idx % n];
      end
    end
    in_valid = 1'b0;
    chk("feed_complete", idx, count);
  endtask

  task automatic wait_done(int limit);
    int g;
    g = 0;
    while (done_cnt == 0 && g < limit) begin
      @(posedge clk); #1;
      g++;
    end
    chk("done_seen", done_cnt, 1);
    @(posedge clk); #1;
  endtask

  task automatic clear_mat();
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) mat[r][c] = 4'd0;
  endtask

  // Compare process: checks the DUT against the model on every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (in_valid && in_ready) begin
          acc_cnt++;
          last_acc_cyc = cyc;
        end
        if (out_valid_size) begin
          chk("hdr_size", int'(out_size), exp_size);
          chk("hdr_no_overlap", int'(out_valid), 0);
          chk("hdr_in_ready", int'(in_ready), 0);
          if (out_ready) hdr_cnt++;
        end
        if (out_valid) begin
          chk("model_has_triple", int'(expq.size() > 0), 1);
          if (expq.size() > 0) begin
            chk("row", int'(out_row), expq[0].r);
            chk("col", int'(out_col), expq[0].c);
            chk("val", int'(out_val), expq[0].v);
            if (first_ov_cyc < 0) first_ov_cyc = cyc;
            if (out_ready) begin
              if (!got_first) begin
                first_trip = expq[0];
                got_first = 1'b1;
              end
              last_trip = '{int'(out_row), int'(out_col), int'(out_val)};
              last_pop_cyc = cyc;
              void'(expq.pop_front());
            end
          end
        end else begin
          chk("fields_zero", int'({out_row, out_col, out_val}), 0);
        end
        if (done) begin
          chk("nnz", int'(nnz), exp_nnz);
          chk("queue_drained", expq.size(), 0);
          chk("all_accepted", acc_cnt, exp_total);
          chk("done_size", int'(out_size), exp_size);
          done_cnt++;
          done_cyc = cyc;
          last_nnz = int'(nnz);
        end
        chk("done_one_cycle", int'(done && prev_done), 0);
      end
      prev_done = done;
    end
  end

  initial begin
    // Reset state.
    clear_mat();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid_size", int'(out_valid_size), 0);
    chk("rst_out_size", int'(out_size), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_fields", int'({out_row, out_col, out_val}), 0);
    chk("rst_done_nnz", int'({done, nnz}), 0);
    @(posedge clk); #1;
    chk_en = 1'b1;

    // 16x16 diagonal of 3s.
    clear_mat();
    for (int k = 0; k < 16; k++) mat[k][k] = 4'd3;
    start_frame(1'b0);
    feed(256);
    wait_done(200);
    chk("diag_nnz", last_nnz, 16);
    chk("diag_last_row", last_trip.r, 15);
    chk("diag_last_col", last_trip.c, 15);
    chk("diag_last_val", last_trip.v, 3);

    // 32x32 all zero.
    clear_mat();
    start_frame(1'b1);
    feed(1024);
    wait_done(200);
    chk("zero_nnz", last_nnz, 0);
    chk("zero_no_triples", first_ov_cyc, -1);

    // 32x32 all 15, with backpressure right after the header.
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) mat[r][c] = 4'd15;
    start_frame(1'b1);
    for (int g = 0; g < 20 && hdr_cnt == 0; g++) begin
      @(posedge clk); #1;
    end
    chk("bp_hdr_seen", hdr_cnt, 1);
    out_ready = 1'b0;
    fork
      feed(1024);
      begin
        repeat (50) @(posedge clk);
        #1;
        chk("bp_accepted", acc_cnt, 8);
        chk("bp_in_ready", int'(in_ready), 0);
        out_ready = 1'b1;
      end
    join
    wait_done(200);
    chk("full_nnz", last_nnz, 1024);

    // 32x32 with a single nonzero in the final cell.
    clear_mat();
    mat[31][31] = 4'd7;
    start_frame(1'b1);
    feed(1024);
    wait_done(200);
    chk("single_nnz", last_nnz, 1);
    chk("single_row", last_trip.r, 31);
    chk("single_col", last_trip.c, 31);
    chk("single_val", last_trip.v, 7);
    chk("single_latency", first_ov_cyc - last_acc_cyc, 1);
    chk("single_done_after_pop", done_cyc - last_pop_cyc, 1);

    // Reset in the middle of a frame while the FIFO holds a triple.
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) mat[r][c] = 4'd5;
    start_frame(1'b0);
    feed(100);
    chk("mid_fifo_nonempty", int'(out_valid), 1);
    chk_en = 1'b0;
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_val = 4'd5;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mrst_in_ready", int'(in_ready), 0);
    chk("mrst_out_valid_size", int'(out_valid_size), 0);
    chk("mrst_out_size", int'(out_size), 0);
    chk("mrst_out_valid", int'(out_valid), 0);
    chk("mrst_fields", int'({out_row, out_col, out_val}), 0);
    chk("mrst_done_nnz", int'({done, nnz}), 0);
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) mat[r][c] = 4'((r * 7 + c * 3 + 9) % 16);
    start_frame(1'b0);
    feed(256);
    wait_done(200);
    chk("post_rst_first_row", first_trip.r, 0);
    chk("post_rst_first_col", first_trip.c, 0);
    chk("post_rst_first_val", first_trip.v, 9);

    // A size strobe during STREAM must be ignored.
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) mat[r][c] = 4'($urandom_range(0, 15));
    start_frame(1'b1);
    fork
      feed(1024);
      begin
        repeat (200) @(posedge clk);
        #1;
        in_valid_size = 1'b1;
        in_size = 1'b0;
        @(posedge clk); #1;
        in_valid_size = 1'b0;
      end
    join
    wait_done(200);
    chk("strobe_one_header", hdr_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sparse_triple_encoder.md
Name: sparse_triple_encoder

Overview:
- Source-side companion to the sparse matrix multiplier.
- Accepts a dense matrix streamed one element per cycle in raster order, discards zero elements, and emits each nonzero element as a (row, col, val) triple.
- Output uses the multiplier's size-header and triple format; a small FIFO decouples input from output, with ready/valid backpressure on both sides.
- Sits between the dense matrix source (memory or bench) and the multiplier's A or B input.

Parameters:
- FIFO_DEPTH, 8, number of triple entries buffered (power of two, minimum 2)
- IDX_W, 5, row/col index width (supports up to 32x32)
- VAL_W, 4, element value width

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  synchronous reset, active-high (asserted = 1); clears all state on the next rising edge
- in_valid_size  in  1  frame start strobe; sampled only in IDLE
- in_size  in  1  0 = 16x16, 1 = 32x32; captured with in_valid_size
- in_valid  in  1  dense element valid
- in_ready  out  1  encoder accepts element this cycle
- in_val  in  VAL_W  dense element value
- out_valid_size  out  1  size header valid
- out_size  out  1  captured size
- out_valid  out  1  triple valid
- out_ready  in  1  downstream accepts header or triple
- out_row  out  IDX_W  triple row
- out_col  out  IDX_W  triple column
- out_val  out  VAL_W  triple value (always nonzero when out_valid = 1)
- done  out  1  one-cycle frame-complete pulse
- nnz  out  11  nonzero count of the frame; valid while done = 1

Behaviour:
- Reset: state = IDLE; FIFO empty; row/col counters = 0; nnz counter = 0.
- Reset values: in_ready, out_valid_size, out_size, out_valid, out_row, out_col, out_val, done, nnz all 0.
- Reset mid-frame aborts the frame, flushes the FIFO, emits no done pulse, and ignores in_valid during reset.
- Frame size N = 16 if size = 0, N = 32 if size = 1.
- States:
  - IDLE: in_valid_size = 1 latches in_size and moves to HDR.
  - HDR: out_valid_size = 1 and out_size = latched size, held until out_ready = 1. The transfer cycle moves to STREAM.
  - STREAM: in_ready = 1 when FIFO is not full. An accepted element (in_valid & in_ready) advances col. On col = N-1, col wraps to 0 and row increments. Acceptance at row = col = N-1 moves to DRAIN.
  - DRAIN: in_ready = 0. Moves to DONE when the FIFO is empty and no pop is pending.
  - DONE: done = 1 for one cycle and nnz = final count. Returns to IDLE; counters and size cleared.
- Element handling:
  - An accepted element with in_val != 0 pushes {row, col, in_val} and increments the nnz counter.
  - An accepted zero element only advances the counters.
- FIFO output:
  - out_valid = FIFO not empty, in STREAM or DRAIN only.
  - out_row, out_col and out_val show the head entry.
  - Pop on out_valid & out_ready.
  - out_row, out_col and out_val are 0 whenever out_valid = 0.
- Latency: a nonzero element accepted at cycle t into an empty FIFO drives out_valid at t+1.
- Ordering: triples are emitted in strict raster order (row-major, ascending col); no reordering, no merging.
- in_ready depends only on state and the registered FIFO count, not on out_ready. A full FIFO blocks input even when a pop occurs in the same cycle.
- Simultaneous push and pop when not full: both occur and the count is unchanged.
- Presenting a triple with out_ready = 0 holds it stable until accepted.
- in_valid_size outside IDLE is ignored; in_valid outside STREAM is ignored.
- nnz range 0..1024 (11 bits), no overflow possible.
- An all-zero frame emits the header, no triples, then done with nnz = 0.
- No out_valid_size during STREAM, DRAIN or DONE; header and triples never overlap.

Test Plan:
- 16x16 matrix with diagonal = 3, else 0, out_ready = 1 -> header out_size = 0; 16 triples (k,k,3) for k = 0..15 in order; done with nnz = 16; 256 elements accepted.
- 32x32 all-zero matrix -> header out_size = 1; out_valid never asserts; done with nnz = 0 once the 1024th element is accepted and DRAIN passes.
- 32x32 all = 15, out_ready held 0 for 50 cycles after the header -> exactly 8 elements accepted, then in_ready = 0. Release out_ready: 1024 raster-order triples; done with nnz = 1024.
- 32x32 with only (31,31) = 7 -> single triple (31,31,7) one cycle after the last accept; done the cycle after it pops; nnz = 1.
- Reset asserted after 100 elements with FIFO nonempty -> next cycle all outputs 0 and state IDLE. A new 16x16 frame then encodes correctly from (0,0).
- in_valid_size pulsed with in_size = 0 during a 32x32 STREAM -> ignored; frame continues to 1024 elements and out_size stays 1.
